// File: rtl/alu_z_stage.sv
// rtl/alu_z_stage.sv - Z result-capture stage with multi-cycle op sequencing
//
// Captures the selected ALU result into the ZHigh/ZLow register pair. Single-cycle
// ops land on the next edge. Multi-cycle ops (MUL/DIV) are launched with a one-cycle
// mc_start pulse, then the stage waits for mc_done under a TIMEOUT-cycle watchdog.
//
// Ports:
//   clk       in   rising-edge clock
//   clr       in   asynchronous active-high reset
//   Zin       in   capture request for the current ALU op
//   mc_op     in   current op is multi-cycle (sampled with Zin)
//   res_lo    in   ALU result low word
//   res_hi    in   ALU result high word
//   res_wide  in   res_hi is meaningful, otherwise ZHigh is loaded with 0
//   mc_done   in   multi-cycle unit finished, res_* valid this cycle
//   mc_start  out  one-cycle launch pulse for the multi-cycle unit
//   busy      out  waiting on the multi-cycle unit
//   z_valid   out  Z pair holds the result of the last accepted op
//   z_err     out  sticky: last multi-cycle op timed out
//   ZLowout   in   drive ZLow on bus_out (priority)
//   ZHighout  in   drive ZHigh on bus_out
//   bus_out   out  selected Z half, combinational
module alu_z_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Zin,
  input  logic              mc_op,
  input  logic [DATA_W-1:0] res_lo,
  input  logic [DATA_W-1:0] res_hi,
  input  logic              res_wide,
  input  logic              mc_done,
  output logic              mc_start,
  output logic              busy,
  output logic              z_valid,
  output logic              z_err,
  input  logic              ZLowout,
  input  logic              ZHighout,
  output logic [DATA_W-1:0] bus_out
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    WAIT_MC
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   zlo_q, zlo_d;
  logic [DATA_W-1:0]   zhi_q, zhi_d;
  logic                mc_start_q, mc_start_d;
  logic                busy_q, busy_d;
  logic                z_valid_q, z_valid_d;
  logic                z_err_q, z_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      zlo_q      <= '0;
      zhi_q      <= '0;
      mc_start_q <= 1'b0;
      busy_q     <= 1'b0;
      z_valid_q  <= 1'b0;
      z_err_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      zlo_q      <= zlo_d;
      zhi_q      <= zhi_d;
      mc_start_q <= mc_start_d;
      busy_q     <= busy_d;
      z_valid_q  <= z_valid_d;
      z_err_q    <= z_err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    zlo_d      = zlo_q;
    zhi_d      = zhi_q;
    mc_start_d = 1'b0;  // launch pulse lasts exactly one cycle
    busy_d     = busy_q;
    z_valid_d  = z_valid_q;
    z_err_d    = z_err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        // mc_done arriving here is stale and deliberately ignored
        if (Zin) begin
          z_err_d = 1'b0;
          if (mc_op) begin
            mc_start_d = 1'b1;
            busy_d     = 1'b1;
            z_valid_d  = 1'b0;
            cnt_d      = '0;
            state_d    = WAIT_MC;
          end else begin
            zlo_d     = res_lo;
            zhi_d     = res_wide ? res_hi : '0;
            z_valid_d = 1'b1;
          end
        end
      end

      WAIT_MC: begin
        // Zin is ignored while waiting; mc_done beats the watchdog on the same cycle
        if (mc_done) begin
          zlo_d     = res_lo;
          zhi_d     = res_wide ? res_hi : '0;
          z_valid_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          z_err_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_out = '0;
    if (ZLowout) begin
      bus_out = zlo_q;
    end else if (ZHighout) begin
      bus_out = zhi_q;
    end
  end

  assign mc_start = mc_start_q;
  assign busy     = busy_q;
  assign z_valid  = z_valid_q;
  assign z_err    = z_err_q;

endmodule

// File: tb/tb_alu_z_stage.sv
// tb/tb_alu_z_stage.sv - directed self-checking bench for alu_z_stage
module tb_alu_z_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        Zin = 1'b0;
  logic        mc_op = 1'b0;
  logic [31:0] res_lo = '0;
  logic [31:0] res_hi = '0;
  logic        res_wide = 1'b0;
  logic        mc_done = 1'b0;
  logic        mc_start;
  logic        busy;
  logic        z_valid;
  logic        z_err;
  logic        ZLowout = 1'b0;
  logic        ZHighout = 1'b0;
  logic [31:0] bus_out;

  int errors = 0;
  int checks = 0;
  int starts;
  int busy_cycles;
  int n;

  alu_z_stage #(.DATA_W(32), .TIMEOUT(64)) dut (
    .clk      (clk),
    .clr      (clr),
    .Zin      (Zin),
    .mc_op    (mc_op),
    .res_lo   (res_lo),
    .res_hi   (res_hi),
    .res_wide (res_wide),
    .mc_done  (mc_done),
    .mc_start (mc_start),
    .busy     (busy),
    .z_valid  (z_valid),
    .z_err    (z_err),
    .ZLowout  (ZLowout),
    .ZHighout (ZHighout),
    .bus_out  (bus_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_lo(input string tag, input logic [31:0] exp);
    ZLowout = 1'b1; ZHighout = 1'b0; #1;
    check(tag, bus_out, exp);
  endtask

  task automatic read_hi(input string tag, input logic [31:0] exp);
    ZLowout = 1'b0; ZHighout = 1'b1; #1;
    check(tag, bus_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    #2 clr = 1'b1;
    #10;
    check("rst_mc_start", mc_start, 0);
    check("rst_busy", busy, 0);
    check("rst_z_valid", z_valid, 0);
    check("rst_z_err", z_err, 0);
    read_lo("rst_zlo", 0);
    read_hi("rst_zhi", 0);
    clr = 1'b0;
    tick();

    // single-cycle capture, narrow result
    Zin = 1; mc_op = 0; res_lo = 32'hF0F0_00FF; res_hi = 32'hDEAD_BEEF; res_wide = 0;
    tick();
    Zin = 0;
    check("sc_z_valid", z_valid, 1);
    check("sc_busy", busy, 0);
    read_lo("sc_zlo", 32'hF0F0_00FF);
    read_hi("sc_zhi_narrow", 0);

    // back-to-back captures
    Zin = 1; res_lo = 32'h1; res_hi = 32'h9; res_wide = 1;
    tick();
    read_lo("b2b_lo0", 32'h1);
    read_hi("b2b_hi0", 32'h9);
    res_lo = 32'h2; res_hi = 32'h3;
    tick();
    Zin = 0;
    read_lo("b2b_lo1", 32'h2);

    // mc_done in IDLE is ignored
    mc_done = 1; res_lo = 32'hBAD;
    tick();
    mc_done = 0;
    read_lo("idle_done_ignored", 32'h2);
    check("idle_done_busy", busy, 0);
    check("idle_done_start", mc_start, 0);

    // multi-cycle op, done after 5 cycles
    Zin = 1; mc_op = 1;
    tick();
    Zin = 0; mc_op = 0;
    check("mc_start_pulse", mc_start, 1);
    check("mc_busy", busy, 1);
    check("mc_z_valid_low", z_valid, 0);
    read_lo("mc_z_unchanged", 32'h2);
    starts = 1; busy_cycles = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mc_start) starts++;
      if (busy) busy_cycles++;
    end
    mc_done = 1; res_hi = 32'h1; res_lo = 32'h8000_0000; res_wide = 1;
    tick();
    mc_done = 0;
    check("mc_starts", starts, 1);
    check("mc_busy_cycles", busy_cycles, 5);
    check("mc_done_busy", busy, 0);
    check("mc_done_valid", z_valid, 1);
    check("mc_done_err", z_err, 0);
    read_lo("mc_zlo", 32'h8000_0000);
    read_hi("mc_zhi", 32'h1);

    // mc_done in the very first WAIT_MC cycle
    Zin = 1; mc_op = 1;
    tick();
    Zin = 0; mc_op = 0;
    check("first_start", mc_start, 1);
    mc_done = 1; res_lo = 32'h11; res_hi = 32'h44; res_wide = 0;
    tick();
    mc_done = 0;
    check("first_busy", busy, 0);
    check("first_valid", z_valid, 1);
    check("first_start_off", mc_start, 0);
    read_lo("first_zlo", 32'h11);
    read_hi("first_zhi", 0);

    // timeout with no mc_done
    Zin = 1; mc_op = 1;
    tick();
    Zin = 0; mc_op = 0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    check("to_busy_cycles", n, 64);
    check("to_z_err", z_err, 1);
    check("to_busy", busy, 0);
    check("to_z_valid", z_valid, 0);
    read_lo("to_zlo_unchanged", 32'h11);
    read_hi("to_zhi_unchanged", 0);
    Zin = 1; res_lo = 32'h22; res_wide = 0;
    tick();
    Zin = 0;
    check("to_err_cleared", z_err, 0);
    check("to_recap_valid", z_valid, 1);
    read_lo("to_recap_lo", 32'h22);

    // Zin held during WAIT_MC, mc_done lands on the timeout cycle
    Zin = 1; mc_op = 1;
    tick();
    starts = mc_start ? 1 : 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (mc_start) starts++;
      if (busy) busy_cycles++;
    end
    mc_done = 1; res_lo = 32'hCAFE_F00D; res_hi = 32'h1234_5678; res_wide = 1;
    tick();
    Zin = 0; mc_op = 0; mc_done = 0;
    check("race_starts", starts, 1);
    check("race_busy_cycles", busy_cycles, 64);
    check("race_z_err", z_err, 0);
    check("race_z_valid", z_valid, 1);
    check("race_busy", busy, 0);
    read_lo("race_zlo", 32'hCAFE_F00D);
    read_hi("race_zhi", 32'h1234_5678);

    // bus_out select priority
    Zin = 1; mc_op = 0; res_lo = 32'hA5A5_A5A5; res_hi = 32'h5A5A_5A5A; res_wide = 1;
    tick();
    Zin = 0;
    ZLowout = 1; ZHighout = 1; #1;
    check("bus_both", bus_out, 32'hA5A5_A5A5);
    ZLowout = 0; ZHighout = 0; #1;
    check("bus_none", bus_out, 0);
    read_hi("bus_hi_only", 32'h5A5A_5A5A);

    // asynchronous clr in the middle of a WAIT_MC cycle
    Zin = 1; mc_op = 1;
    tick();
    Zin = 0; mc_op = 0;
    check("clr_pre_busy", busy, 1);
    #3 clr = 1'b1;
    #1;
    check("clr_mc_start", mc_start, 0);
    check("clr_busy", busy, 0);
    check("clr_z_valid", z_valid, 0);
    check("clr_z_err", z_err, 0);
    read_lo("clr_zlo", 0);
    read_hi("clr_zhi", 0);
    #1 clr = 1'b0;
    Zin = 1; res_lo = 32'h77; res_wide = 0;
    tick();
    Zin = 0;
    check("clr_idle_capture", z_valid, 1);
    check("clr_idle_busy", busy, 0);
    read_lo("clr_idle_lo", 32'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
